// File: rtl/cfg_chain_ctrl_if.sv
// Register-side request/response bundle for cfg_chain_ctrl.
// Handshake: a request (wr_req or rd_req) is a level held by the master. The controller
// samples it only on an edge where it is free, and answers with a one-cycle ack.
// Until ack is seen, the request is not guaranteed to be taken. busy covers the
// whole operation, and done pulses once when the operation completes.
interface cfg_chain_ctrl_if #(
  parameter int N = 32
);
  logic         wr_req;
  logic [N-1:0] wr_data;
  logic         rd_req;
  logic         ack;
  logic         busy;
  logic         done;
  logic [N-1:0] rd_data;

  modport master (
    output wr_req, wr_data, rd_req,
    input  ack, busy, done, rd_data
  );

  modport slave (
    input  wr_req, wr_data, rd_req,
    output ack, busy, done, rd_data
  );
endinterface

// File: rtl/cfg_chain_ctrl.sv
// Serial config-chain sequencer: shifts write words LSB-first and pulses the load strobe; optional readback.
// Readback (CAPT/RDSHIFT, rd_shift, rd_data) is built only when CFG_CHAIN_READBACK_EN is defined.
module cfg_chain_ctrl #(
  parameter int N = 32
) (
  input  logic              clk,
  input  logic              reset,
  cfg_chain_ctrl_if.slave   bus,
  output logic              sr_s_in,
  output logic              sr_load,
  output logic              sr_read,
  input  logic              sr_s_out,
  output logic [2:0]        o_dbg_state
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SHIFT   = 3'd1,
    S_LOAD    = 3'd2,
    S_CAPT    = 3'd3,
    S_RDSHIFT = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [N-1:0]  r_shadow;
  logic [CW-1:0] r_cnt;
  logic          r_ack;
  logic          r_done;
  logic          w_last;
  logic          w_open;
  logic          w_start_wr;
  logic          w_start_rd;
  logic          w_done;

  assign w_last = (r_cnt == LAST);

  // The closing edge of an operation (LOAD, last RDSHIFT) also serves as an accept
  // edge, so back-to-back operations issue every N+1 cycles.
  always_comb begin
    w_next_state = r_state;
    w_open       = 1'b0;
    w_done       = 1'b0;
    w_start_wr   = 1'b0;
    w_start_rd   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_open = 1'b1;
      end
      S_SHIFT: begin
        if (w_last) w_next_state = S_LOAD;
      end
      S_LOAD: begin
        w_done       = 1'b1;
        w_open       = 1'b1;
        w_next_state = S_IDLE;
      end
`ifdef CFG_CHAIN_READBACK_EN
      S_CAPT: begin
        w_next_state = S_RDSHIFT;
      end
      S_RDSHIFT: begin
        if (w_last) begin
          w_done       = 1'b1;
          w_open       = 1'b1;
          w_next_state = S_IDLE;
        end
      end
`endif
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
    if (w_open) begin
      if (bus.wr_req) begin
        w_start_wr   = 1'b1;
        w_next_state = S_SHIFT;
      end
`ifdef CFG_CHAIN_READBACK_EN
      else if (bus.rd_req) begin
        w_start_rd   = 1'b1;
        w_next_state = S_CAPT;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_shadow <= '0;
      r_cnt    <= '0;
      r_ack    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_ack   <= w_start_wr | w_start_rd;
      r_done  <= w_done;
      if (w_start_wr) begin
        r_shadow <= bus.wr_data;
        r_cnt    <= '0;
      end else if (r_state == S_SHIFT) begin
        r_shadow <= r_shadow >> 1;
        r_cnt    <= r_cnt + 1'b1;
      end else if (r_state == S_CAPT) begin
        r_cnt <= '0;
      end else if (r_state == S_RDSHIFT) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

`ifdef CFG_CHAIN_READBACK_EN
  logic [N-1:0] r_rd_shift;
  logic [N-1:0] r_rd_data;
  logic [N-1:0] w_rd_next;

  // Bit k of the captured word appears on sr_s_out one cycle after the previous bit.
  assign w_rd_next = {sr_s_out, r_rd_shift[N-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_shift <= '0;
      r_rd_data  <= '0;
    end else if (r_state == S_RDSHIFT) begin
      r_rd_shift <= w_rd_next;
      if (w_last) r_rd_data <= w_rd_next;
    end
  end

  assign bus.rd_data = r_rd_data;
  assign sr_read     = (r_state == S_CAPT);
`else
  logic w_unused;
  assign w_unused    = ^{bus.rd_req, sr_s_out, w_start_rd};
  assign bus.rd_data = '0;
  assign sr_read     = 1'b0;
`endif

  assign bus.ack     = r_ack;
  assign bus.done    = r_done;
  assign bus.busy    = (r_state != S_IDLE);
  assign sr_load     = (r_state == S_LOAD);
  assign sr_s_in     = (r_state == S_SHIFT) & r_shadow[0];
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cfg_chain_ctrl.sv
// Bench for cfg_chain_ctrl (N=8) driving a behavioural config-chain model.
// Readback expectations follow CFG_CHAIN_READBACK_EN as compiled.
module tb_cfg_chain_ctrl;
  localparam int N = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic chain_rst;
  always #5 clk = ~clk;

  cfg_chain_ctrl_if #(.N(N)) bus ();
  logic       sr_s_in, sr_load, sr_read, sr_s_out;
  logic [2:0] dbg_state;

  cfg_chain_ctrl #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .sr_s_in    (sr_s_in),
    .sr_load    (sr_load),
    .sr_read    (sr_read),
    .sr_s_out   (sr_s_out),
    .o_dbg_state(dbg_state)
  );

  // Chain model: shifts toward bit 0 unless a strobe is high.
  logic [N-1:0] chain_sr, chain_latch, par_in;
  always_ff @(posedge clk or posedge chain_rst) begin
    if (chain_rst) begin
      chain_sr    <= '0;
      chain_latch <= '0;
    end else if (sr_load) chain_latch <= chain_sr;
    else if (sr_read) chain_sr <= par_in;
    else chain_sr <= {sr_s_in, chain_sr[N-1:1]};
  end
  assign sr_s_out = chain_sr[0];

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [N-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_op(input bit is_rd, input logic [N-1:0] data, input logic [N-1:0] exp_val);
    logic [N-1:0] latch_before;
    logic [N-1:0] exp_front;
    latch_before = chain_latch;
    exp_q.push_back(exp_val);
    @(negedge clk);
    if (is_rd) bus.rd_req = 1'b1;
    else begin
      bus.wr_req  = 1'b1;
      bus.wr_data = data;
    end
    @(negedge clk);
    bus.wr_req  = 1'b0;
    bus.rd_req  = 1'b0;
    bus.wr_data = ~data;
    for (int c = 0; c <= N + 1; c++) begin
      if (c > 0) @(negedge clk);
      chk("ack", bus.ack, c == 0);
      chk("busy", bus.busy, c <= N);
      chk("done", bus.done, c == N + 1);
      chk("sr_load", sr_load, !is_rd && c == N);
      chk("sr_read", sr_read, is_rd && c == 0);
      chk("sr_s_in", sr_s_in, (!is_rd && c < N) ? data[c] : 1'b0);
    end
    exp_front = exp_q.pop_front();
    if (is_rd) begin
      chk("rd_data", bus.rd_data, exp_front);
      chk("latch_kept", chain_latch, latch_before);
    end else begin
      chk("latch", chain_latch, exp_front);
    end
  endtask

  typedef struct {
    bit           is_rd;
    logic [N-1:0] data;
    logic [N-1:0] par;
    logic [N-1:0] exp_val;
  } vec_t;
  vec_t vecs[6];

  bit saw_load, saw_done, found;
  logic [7:0] rnd;

  initial begin
    bus.wr_req = 1'b0; bus.rd_req = 1'b0; bus.wr_data = '0;
    par_in = '0;
    reset = 1'b1; chain_rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; chain_rst = 1'b0;

    // Idle after reset: every output low, latch untouched.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_outs", {bus.ack, bus.busy, bus.done, sr_s_in, sr_load, sr_read, bus.rd_data}, '0);
    end
    chk("idle_latch", chain_latch, 8'h00);

    // Reset during cycle 4 of a 0xFF write aborts without loading.
    @(negedge clk);
    bus.wr_req = 1'b1; bus.wr_data = 8'hFF;
    @(negedge clk);
    bus.wr_req = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    #1 chk("abort_busy", bus.busy, 1'b0);
    chk("abort_load", sr_load, 1'b0);
    saw_load = 1'b0; saw_done = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (sr_load) saw_load = 1'b1;
      if (bus.done) saw_done = 1'b1;
    end
    chk("abort_no_load", saw_load, 1'b0);
    chk("abort_no_done", saw_done, 1'b0);
    chk("abort_latch", chain_latch, 8'h00);
    run_op(1'b0, 8'h81, 8'h81);

    // Table of single operations.
    rnd = 8'($urandom_range(0, 255));
    vecs[0] = '{1'b0, 8'hA5, 8'h00, 8'hA5};
    vecs[1] = '{1'b1, 8'h00, 8'h3C, 8'h3C};
    vecs[2] = '{1'b0, 8'h00, 8'h00, 8'h00};
    vecs[3] = '{1'b0, 8'hFF, 8'h00, 8'hFF};
    vecs[4] = '{1'b0, rnd,   8'h00, rnd};
    rnd = 8'($urandom_range(0, 255));
    vecs[5] = '{1'b1, 8'h00, rnd,   rnd};
    for (int i = 0; i < 6; i++) begin
`ifndef CFG_CHAIN_READBACK_EN
      if (vecs[i].is_rd) continue;
`endif
      par_in = vecs[i].par;
      run_op(vecs[i].is_rd, vecs[i].data, vecs[i].exp_val);
    end

    // Write and read raised together: write first, read after.
    par_in = 8'hC3;
    @(negedge clk);
    bus.wr_req = 1'b1; bus.wr_data = 8'h5A; bus.rd_req = 1'b1;
    @(negedge clk);
    bus.wr_req = 1'b0;
    chk("prio_ack", bus.ack, 1'b1);
    chk("prio_no_read", sr_read, 1'b0);
    repeat (N + 1) @(negedge clk);
    chk("prio_wr_done", bus.done, 1'b1);
    chk("prio_latch", chain_latch, 8'h5A);
`ifdef CFG_CHAIN_READBACK_EN
    found = 1'b0;
    for (int k = 0; k < N + 4 && !found; k++) begin
      if (k > 0) @(negedge clk);
      if (bus.ack) found = 1'b1;
    end
    chk("prio_rd_ack", found, 1'b1);
    bus.rd_req = 1'b0;
    found = 1'b0;
    for (int k = 0; k < N + 4 && !found; k++) begin
      @(negedge clk);
      if (bus.done) found = 1'b1;
    end
    chk("prio_rd_done", found, 1'b1);
    chk("prio_rd_data", bus.rd_data, 8'hC3);
    chk("prio_latch_kept", chain_latch, 8'h5A);
`else
    // Readback absent: a held rd_req never gets a response.
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("norb_outs", {bus.ack, bus.busy, sr_read}, 3'b000);
      chk("norb_rd_data", bus.rd_data, 8'h00);
    end
    bus.rd_req = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("end_idle", bus.busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
